// File: rtl/basic_rw_sink.sv
`default_nettype none
// ============================================================================
// Module   : basic_rw_sink
// Purpose  : Accepts a handshaked scalar word stream and scatters the first
//            32 accepted words into two multi-dimensional unpacked array
//            outputs (24 into b, the next 8 into c) so the array-read path of
//            a bench has a sequential source with known contents. Also keeps
//            a running word count and a wrap-around sum of accepted words.
// Ports    : clk      - clock, all state changes on the rising edge
//            rst      - asynchronous reset, active-low
//            i_valid  - an input word is offered this cycle
//            i_data   - input word, DW bits
//            i_clear  - synchronous restart (count/sum to 0, arrays kept)
//            o_ready  - high in FILL_B / FILL_C
//            b        - [3][2][4] x DW, words 0..23 (last index fastest)
//            c        - [2][4] x DW, words 24..31
//            o_count  - accepted words since last reset or clear (0..32)
//            o_sum    - sum of accepted words modulo 2^DW
//            o_done   - high once all 32 words are captured
// Revision : 1.0 - initial release
// ============================================================================
module basic_rw_sink #(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic          i_clear,
    output logic          o_ready,
    output logic [DW-1:0] b [3][2][4],
    output logic [DW-1:0] c [2][4],
    output logic [5:0]    o_count,
    output logic [DW-1:0] o_sum,
    output logic          o_done
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FILL_B = 2'd1;
    localparam logic [1:0] c_FILL_C = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [5:0] c_LAST_B = 6'd23;
    localparam logic [5:0] c_LAST_C = 6'd31;

    logic [1:0]    r_state;
    logic [5:0]    r_count;
    logic [DW-1:0] r_sum;
    logic [DW-1:0] r_b [3][2][4];
    logic [DW-1:0] r_c [2][4];

    logic          w_accept;
    logic          w_accept_b;
    logic          w_accept_c;

    assign o_ready    = (r_state == c_FILL_B) || (r_state == c_FILL_C);
    assign o_done     = (r_state == c_DONE);

    // Clear wins over a simultaneous valid word: that word is dropped.
    assign w_accept   = i_valid && o_ready && !i_clear;
    assign w_accept_b = w_accept && (r_state == c_FILL_B);
    assign w_accept_c = w_accept && (r_state == c_FILL_C);

    assign o_count = r_count;
    assign o_sum   = r_sum;
    assign b       = r_b;
    assign c       = r_c;

    // ------------------------------------------------------------------
    // Control: state, word counter and running sum
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_count <= 6'd0;
            r_sum   <= '0;
        end else if (i_clear) begin
            r_state <= c_IDLE;
            r_count <= 6'd0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_state <= c_FILL_B;
                end
                c_FILL_B: begin
                    if (w_accept) begin
                        r_count <= r_count + 6'd1;
                        r_sum   <= r_sum + i_data;
                        if (r_count == c_LAST_B) begin
                            r_state <= c_FILL_C;
                        end
                    end
                end
                c_FILL_C: begin
                    if (w_accept) begin
                        r_count <= r_count + 6'd1;
                        r_sum   <= r_sum + i_data;
                        if (r_count == c_LAST_C) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= c_DONE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Array capture. Clear leaves contents alone; only reset zeroes them.
    // In FILL_B the count is 0..23, so its bit fields map straight onto
    // [n/8][(n/4)%2][n%4]. In FILL_C the count is 24..31 = 5'b11xxx, so the
    // low three bits are already n-24.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 2; j++) begin
                    for (int k = 0; k < 4; k++) begin
                        r_b[i][j][k] <= '0;
                    end
                end
            end
        end else if (w_accept_b) begin
            r_b[r_count[4:3]][r_count[2]][r_count[1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < 2; j++) begin
                for (int k = 0; k < 4; k++) begin
                    r_c[j][k] <= '0;
                end
            end
        end else if (w_accept_c) begin
            r_c[r_count[2]][r_count[1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_basic_rw_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_basic_rw_sink
// Purpose  : Self-checking bench for basic_rw_sink. A small behavioural
//            model tracks state/count/sum; accepted words are queued with
//            their flat index and compared against the array element after
//            the capturing edge. A vector table covers the clear/handshake
//            corners, hand sequences cover fill, wrap, hold, clear, reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_basic_rw_sink;

    localparam int DW = 11;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          i_clear;
    logic          o_ready;
    logic [DW-1:0] b [3][2][4];
    logic [DW-1:0] c [2][4];
    logic [5:0]    o_count;
    logic [DW-1:0] o_sum;
    logic          o_done;

    basic_rw_sink #(.DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_clear (i_clear),
        .o_ready (o_ready),
        .b       (b),
        .c       (c),
        .o_count (o_count),
        .o_sum   (o_sum),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // bench model
    int            m_state;   // 0 idle, 1 fill_b, 2 fill_c, 3 done
    logic [5:0]    m_count;
    logic [DW-1:0] m_sum;

    typedef struct {
        logic [5:0]    idx;
        logic [DW-1:0] data;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          clr;
        logic          exp_ready;
        logic [5:0]    exp_count;
        logic [DW-1:0] exp_sum;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] get_elem(input int n);
        logic [5:0] nn;
        logic [5:0] m;
        nn = 6'(n);
        m  = nn - 6'd24;
        if (n < 24) return b[nn[4:3]][nn[2]][nn[1:0]];
        else        return c[m[2]][m[1:0]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of stimulus, advance the model, then check all
    // scalar outputs and the element written by any accepted word.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic clr);
        logic  m_ready;
        logic  acc;
        sb_t   e;
        i_valid = v;
        i_data  = d;
        i_clear = clr;
        m_ready = (m_state == 1) || (m_state == 2);
        acc     = v && m_ready && !clr;
        if (acc) sb.push_back('{idx: m_count, data: d});
        if (clr) begin
            m_state = 0;
            m_count = 6'd0;
            m_sum   = '0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (acc) begin
            m_count = m_count + 6'd1;
            m_sum   = m_sum + d;
            if (m_count == 6'd24) m_state = 2;
            if (m_count == 6'd32) m_state = 3;
        end
        tick();
        check("ready", 32'(o_ready), 32'((m_state == 1) || (m_state == 2)));
        check("done",  32'(o_done),  32'(m_state == 3));
        check("count", 32'(o_count), 32'(m_count));
        check("sum",   32'(o_sum),   32'(m_sum));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("elem%0d", e.idx), 32'(get_elem(int'(e.idx))), 32'(e.data));
        end
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_data  = '0;
        rst     = 1'b0;
        tick();
        tick();
        rst     = 1'b1;
        m_state = 0;
        m_count = 6'd0;
        m_sum   = '0;
        sb.delete();
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_done",  32'(o_done),  32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_sum",   32'(o_sum),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int first_done;

    initial begin
        // {valid, data, clear, exp_ready, exp_count, exp_sum} after the edge
        tbl[0] = '{1'b0, 11'd0,    1'b0, 1'b1, 6'd0, 11'd0};    // IDLE -> FILL_B
        tbl[1] = '{1'b1, 11'd3,    1'b0, 1'b1, 6'd1, 11'd3};
        tbl[2] = '{1'b1, 11'd4,    1'b1, 1'b0, 6'd0, 11'd0};    // clear drops word
        tbl[3] = '{1'b1, 11'd9,    1'b0, 1'b1, 6'd0, 11'd0};    // IDLE ignores valid
        tbl[4] = '{1'b1, 11'd2047, 1'b0, 1'b1, 6'd1, 11'd2047};
        tbl[5] = '{1'b1, 11'd2,    1'b0, 1'b1, 6'd2, 11'd1};    // wraps
        tbl[6] = '{1'b0, 11'd6,    1'b0, 1'b1, 6'd2, 11'd1};
        tbl[7] = '{1'b1, 11'd5,    1'b1, 1'b0, 6'd0, 11'd0};
        tbl[8] = '{1'b0, 11'd0,    1'b1, 1'b0, 6'd0, 11'd0};    // clear held
        tbl[9] = '{1'b0, 11'd0,    1'b0, 1'b1, 6'd0, 11'd0};

        rst = 1'b0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_data  = '0;
        tick();
        do_reset();
        check("rst_b000", 32'(b[0][0][0]), 32'd0);
        check("rst_c13",  32'(c[1][3]),    32'd0);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].clr);
            check($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'(tbl[i].exp_ready));
            check($sformatf("tbl%0d_count", i), 32'(o_count), 32'(tbl[i].exp_count));
            check($sformatf("tbl%0d_sum", i),   32'(o_sum),   32'(tbl[i].exp_sum));
        end

        // Reset, then 32 back-to-back words 1..32
        do_reset();
        first_done = 0;
        drive(1'b0, '0, 1'b0);
        check("ready_first_edge", 32'(o_ready), 32'd1);
        for (int i = 1; i <= 32; i++) begin
            drive(1'b1, DW'(i), 1'b0);
            if (o_done && first_done == 0) first_done = i + 1;
            if (i == 24) check("ready_at_boundary", 32'(o_ready), 32'd1);
            if (i == 25) begin
                check("c00_after_word24", 32'(c[0][0]), 32'd25);
                check("ready_after_boundary", 32'(o_ready), 32'd1);
            end
        end
        check("done_edge", 32'(first_done), 32'd33);
        check("b000", 32'(b[0][0][0]), 32'd1);
        check("b013", 32'(b[0][1][3]), 32'd8);
        check("b213", 32'(b[2][1][3]), 32'd24);
        check("c00",  32'(c[0][0]),    32'd25);
        check("c13",  32'(c[1][3]),    32'd32);
        check("full_count", 32'(o_count), 32'd32);
        check("full_sum",   32'(o_sum),   32'd528);
        check("full_done",  32'(o_done),  32'd1);

        // DONE ignores valid
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 11'd5, 1'b0);
            check("hold_ready", 32'(o_ready), 32'd0);
        end
        check("hold_count", 32'(o_count), 32'd32);
        check("hold_sum",   32'(o_sum),   32'd528);
        check("hold_b000",  32'(b[0][0][0]), 32'd1);
        check("hold_c13",   32'(c[1][3]),    32'd32);

        // Toggling valid with 0x7FF, checks wrap of the sum
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            drive((i % 2) == 0, 11'h7FF, 1'b0);
        end
        check("tog_count", 32'(o_count), 32'd32);
        check("tog_sum",   32'(o_sum),   32'h7E0);
        check("tog_done",  32'(o_done),  32'd1);
        for (int n = 0; n < 32; n++) begin
            check($sformatf("tog_elem%0d", n), 32'(get_elem(n)), 32'h7FF);
        end

        // Clear after 10 words, together with a valid word
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, DW'(100 + i), 1'b0);
        drive(1'b1, 11'd77, 1'b1);
        check("clr_count", 32'(o_count), 32'd0);
        check("clr_sum",   32'(o_sum),   32'd0);
        check("clr_ready", 32'(o_ready), 32'd0);
        check("clr_b003",  32'(b[0][0][3]), 32'd103);
        check("clr_b010",  32'(b[0][1][0]), 32'd104);
        drive(1'b0, '0, 1'b0);
        check("clr_ready_back", 32'(o_ready), 32'd1);
        check("clr_b000_kept",  32'(b[0][0][0]), 32'd100);
        drive(1'b1, 11'd200, 1'b0);
        check("clr_b000_new", 32'(b[0][0][0]), 32'd200);
        check("clr_b001_old", 32'(b[0][0][1]), 32'd101);

        // Fill into FILL_C, then asynchronous reset mid-cycle
        for (int i = 0; i < 27; i++) drive(1'b1, DW'(300 + i), 1'b0);
        check("pre_rst_count", 32'(o_count), 32'd28);
        i_valid = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check("arst_count", 32'(o_count), 32'd0);
        check("arst_sum",   32'(o_sum),   32'd0);
        check("arst_ready", 32'(o_ready), 32'd0);
        check("arst_done",  32'(o_done),  32'd0);
        for (int n = 0; n < 32; n++) begin
            check($sformatf("arst_elem%0d", n), 32'(get_elem(n)), 32'd0);
        end
        i_valid = 1'b0;
        tick();
        rst = 1'b1;
        m_state = 0;
        m_count = 6'd0;
        m_sum   = '0;
        sb.delete();
        drive(1'b0, '0, 1'b0);
        drive(1'b1, 11'd42, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
